mcu6502_top: RTL and testbench



---
 rtl/mcu6502_top.sv | 114 +++++++++++
 tb/tb_mcu6502_top.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu6502_top.sv
// mcu6502_top: 6502-subset microcomputer, multi-cycle core with on-chip ROM and RAM
module mcu6502_mem #(
  parameter int ROM_WORDS = 4096,
  parameter int RAM_WORDS = 2048
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic [7:0]  rdata_o
);
  logic [7:0] ROM [ROM_WORDS];
  logic [7:0] RAM [RAM_WORDS];
  logic rom_sel, ram_sel;
  assign rom_sel = addr_i[15:12] == 4'hF;
  assign ram_sel = addr_i[15:11] == 5'd0;
  assign rdata_o = rom_sel ? ROM[addr_i[11:0]] : ram_sel ? RAM[addr_i[10:0]] : 8'h00;
  // RAM write lands on the edge of the write cycle; ROM and unmapped space ignore writes
  always_ff @(posedge clk_i) begin
    if (we_i && ram_sel) RAM[addr_i[10:0]] <= wdata_i;
  end
endmodule

module mcu6502_top #(
  parameter int ROM_WORDS = 4096,
  parameter int RAM_WORDS = 2048
) (
  input logic ph1,
  input logic ph2,
  input logic reset
);
  typedef enum logic [2:0] {VECL, VECH, FETCH, OP1, OP2, EXEC} state_e;
  state_e state_q;
  logic [7:0] a_q, x_q, y_q, ir_q, rdata, wdata, wval;
  logic [15:0] pc_q, al_q, bus_addr;
  logic n_q, z_q, we, ld, wa, wx, wy;
  logic is_imm, is_zp, is_abs, is_jmp, is_ld, is_st, is_tax, is_tay, is_txa, is_tya;
  logic unused_ph2;
  assign unused_ph2 = ph2;
  assign is_imm = ir_q inside {8'hA9, 8'hA2, 8'hA0};
  assign is_zp  = ir_q inside {8'hA5, 8'hA6, 8'hA4, 8'h85, 8'h86, 8'h84};
  assign is_abs = ir_q inside {8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C};
  assign is_jmp = ir_q == 8'h4C;
  assign is_st  = (is_zp || is_abs) && ir_q[7:5] == 3'b100;
  assign is_ld  = (is_zp || is_abs) && !is_st;
  assign is_tax = ir_q == 8'hAA;
  assign is_tay = ir_q == 8'hA8;
  assign is_txa = ir_q == 8'h8A;
  assign is_tya = ir_q == 8'h98;
  // register writeback selection and bus drive; low opcode bits pick A (01), X (10) or Y (00)
  always_comb begin
    ld = (state_q == OP1 && is_imm) || (state_q == EXEC && is_ld);
    wval = is_txa ? x_q : is_tya ? y_q : (is_tax || is_tay) ? a_q : rdata;
    wa = (ld && ir_q[1:0] == 2'b01) || (state_q == OP1 && (is_txa || is_tya));
    wx = (ld && ir_q[1:0] == 2'b10) || (state_q == OP1 && is_tax);
    wy = (ld && ir_q[1:0] == 2'b00) || (state_q == OP1 && is_tay);
    wdata = ir_q[1:0] == 2'b01 ? a_q : ir_q[1:0] == 2'b10 ? x_q : y_q;
    bus_addr = state_q == VECL ? 16'hFFFC : state_q == VECH ? 16'hFFFD : state_q == EXEC ? al_q : pc_q;
    we = state_q == EXEC && is_st && !reset;
  end
  mcu6502_mem #(.ROM_WORDS(ROM_WORDS), .RAM_WORDS(RAM_WORDS)) mem (
    .clk_i(ph1),
    .we_i(we),
    .addr_i(bus_addr),
    .wdata_i(wdata),
    .rdata_o(rdata)
  );
  // core sequencer: vector fetch, opcode fetch, operand bytes, then memory access
  always_ff @(posedge ph1) begin
    if (reset) begin
      a_q <= 8'h00;
      x_q <= 8'h00;
      y_q <= 8'h00;
      n_q <= 1'b0;
      z_q <= 1'b0;
      pc_q <= 16'h0000;
      state_q <= VECL;
    end else begin
      if (wa) a_q <= wval;
      if (wx) x_q <= wval;
      if (wy) y_q <= wval;
      if (wa || wx || wy) begin
        n_q <= wval[7];
        z_q <= wval == 8'h00;
      end
      case (state_q)
        VECL: begin
          pc_q[7:0] <= rdata;
          state_q <= VECH;
        end
        VECH: begin
          pc_q[15:8] <= rdata;
          state_q <= FETCH;
        end
        FETCH: begin
          ir_q <= rdata;
          pc_q <= pc_q + 16'd1;
          state_q <= OP1;
        end
        OP1: begin
          if (is_imm || is_zp || is_abs || is_jmp) pc_q <= pc_q + 16'd1;
          al_q <= {8'h00, rdata};
          state_q <= is_zp ? EXEC : (is_abs || is_jmp) ? OP2 : FETCH;
        end
        OP2: begin
          pc_q <= is_jmp ? {rdata, al_q[7:0]} : pc_q + 16'd1;
          al_q[15:8] <= rdata;
          state_q <= is_jmp ? FETCH : EXEC;
        end
        default: state_q <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mcu6502_top.sv
// tb_mcu6502_top: directed and random programs checked against an instruction-level model
module tb_mcu6502_top;
  logic ph1 = 1'b0, ph2, reset = 1'b1;
  int n_chk = 0, n_fail = 0, cyc_total = 0;
  logic [7:0] m_rom [4096];
  logic [7:0] m_ram [2048];
  logic [7:0] m_r [3];
  logic [15:0] m_pc, pa;
  logic m_n, m_z;

  always #5 ph1 = ~ph1;
  assign ph2 = ~ph1;

  mcu6502_top dut (.ph1(ph1), .ph2(ph2), .reset(reset));

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_imm(input logic [7:0] op);
    return op inside {8'hA9, 8'hA2, 8'hA0};
  endfunction
  function automatic bit is_zp(input logic [7:0] op);
    return op inside {8'hA5, 8'hA6, 8'hA4, 8'h85, 8'h86, 8'h84};
  endfunction
  function automatic bit is_abs(input logic [7:0] op);
    return op inside {8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C};
  endfunction
  function automatic bit supported(input logic [7:0] op);
    return is_imm(op) || is_zp(op) || is_abs(op) || (op inside {8'hAA, 8'hA8, 8'h8A, 8'h98, 8'hEA, 8'h4C});
  endfunction
  function automatic logic [7:0] rd(input logic [15:0] a);
    return a >= 16'hF000 ? m_rom[a[11:0]] : a < 16'h0800 ? m_ram[a[10:0]] : 8'h00;
  endfunction

  task automatic put(input int r, input logic [7:0] v);
    m_r[r] = v;
    m_n = v[7];
    m_z = v == 8'h00;
  endtask

  // one whole instruction at architectural level; returns its cycle count
  task automatic m_step(output int cyc);
    logic [7:0] op;
    logic [15:0] ea;
    int r;
    op = rd(m_pc);
    m_pc++;
    r = (op inside {8'hA9, 8'hA5, 8'hAD, 8'h85, 8'h8D}) ? 0 :
        (op inside {8'hA2, 8'hA6, 8'hAE, 8'h86, 8'h8E}) ? 1 : 2;
    cyc = 2;
    if (is_imm(op)) begin
      put(r, rd(m_pc));
      m_pc++;
    end else if (is_zp(op) || is_abs(op)) begin
      ea = {8'h00, rd(m_pc)};
      m_pc++;
      cyc = 3;
      if (is_abs(op)) begin
        ea[15:8] = rd(m_pc);
        m_pc++;
        cyc = 4;
      end
      if (op[7:4] == 4'hA) put(r, rd(ea));
      else if (ea < 16'h0800) m_ram[ea[10:0]] = m_r[r];
    end else if (op == 8'h4C) begin
      ea[7:0] = rd(m_pc);
      m_pc++;
      ea[15:8] = rd(m_pc);
      m_pc = ea;
      cyc = 3;
    end else if (op == 8'hAA) put(1, m_r[0]);
    else if (op == 8'hA8) put(2, m_r[0]);
    else if (op == 8'h8A) put(0, m_r[1]);
    else if (op == 8'h98) put(0, m_r[2]);
    cyc_total += cyc;
  endtask

  task automatic check_state(input string tag);
    chk({tag, " pc"}, dut.pc_q, m_pc);
    chk({tag, " fetch addr"}, dut.bus_addr, m_pc);
    chk({tag, " a"}, dut.a_q, m_r[0]);
    chk({tag, " x"}, dut.x_q, m_r[1]);
    chk({tag, " y"}, dut.y_q, m_r[2]);
    chk({tag, " n"}, dut.n_q, m_n);
    chk({tag, " z"}, dut.z_q, m_z);
  endtask

  task automatic step(input string tag);
    int c;
    m_step(c);
    repeat (c) @(negedge ph1);
    check_state(tag);
  endtask

  task automatic chk_images(input string tag);
    int d;
    d = 0;
    for (int i = 0; i < 2048; i++) if (dut.mem.RAM[i] !== m_ram[i]) d++;
    chk({tag, " ram diffs"}, d, 0);
    d = 0;
    for (int i = 0; i < 4096; i++) if (dut.mem.ROM[i] !== m_rom[i]) d++;
    chk({tag, " rom diffs"}, d, 0);
  endtask

  task automatic clear(input logic [15:0] vec);
    for (int i = 0; i < 4096; i++) m_rom[i] = 8'hEA;
    for (int i = 0; i < 2048; i++) m_ram[i] = 8'h00;
    m_rom[12'hFFC] = vec[7:0];
    m_rom[12'hFFD] = vec[15:8];
    pa = vec;
    cyc_total = 0;
  endtask

  task automatic emit(input logic [7:0] b);
    m_rom[pa[11:0]] = b;
    pa++;
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    repeat (hold) @(negedge ph1);
    chk("reset pc", dut.pc_q, 0);
    chk("reset a", dut.a_q, 0);
    chk("reset x", dut.x_q, 0);
    chk("reset y", dut.y_q, 0);
    chk("reset nz", {dut.n_q, dut.z_q}, 0);
    reset = 1'b0;
    m_r = '{default: 8'h00};
    m_n = 1'b0;
    m_z = 1'b0;
    repeat (2) @(negedge ph1);
    m_pc = {m_rom[12'hFFD], m_rom[12'hFFC]};
    cyc_total = 0;
    check_state("vector");
  endtask

  task automatic boot(input int hold);
    reset = 1'b1;
    @(negedge ph1);
    for (int i = 0; i < 4096; i++) dut.mem.ROM[i] = m_rom[i];
    for (int i = 0; i < 2048; i++) dut.mem.RAM[i] = m_ram[i];
    do_reset(hold);
  endtask

  task automatic gen_random(input int n);
    logic [7:0] ops [20] = '{8'hA9, 8'hA2, 8'hA0, 8'hA5, 8'hA6, 8'hA4, 8'hAD, 8'hAE, 8'hAC, 8'h85,
                             8'h86, 8'h84, 8'h8D, 8'h8E, 8'h8C, 8'hAA, 8'hA8, 8'h8A, 8'h98, 8'hEA};
    logic [15:0] edges [6] = '{16'h07FF, 16'h0800, 16'hEFFF, 16'hF000, 16'h0000, 16'hFFFF};
    clear(16'hF000);
    for (int i = 0; i < 4096; i++) m_rom[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) m_ram[i] = 8'($urandom);
    m_rom[12'hFFC] = 8'h00;
    m_rom[12'hFFD] = 8'hF0;
    for (int i = 0; i < n; i++) begin
      int k;
      logic [7:0] op;
      logic [15:0] t;
      k = $urandom_range(0, 21);
      op = k < 20 ? ops[k] : k == 20 ? 8'h4C : 8'h00;
      if (k == 21) do op = 8'($urandom); while (supported(op));
      t = pa + 16'd3;
      emit(op);
      if (op == 8'h4C) begin
        emit(t[7:0]);
        emit(t[15:8]);
      end else if (is_imm(op) || is_zp(op)) emit(8'($urandom));
      else if (is_abs(op)) begin
        case ($urandom_range(0, 3))
          0: t = 16'($urandom_range(0, 16'h07FF));
          1: t = 16'($urandom_range(16'h0800, 16'hEFFF));
          2: t = 16'($urandom_range(16'hF000, 16'hFFFF));
          default: t = edges[$urandom_range(0, 5)];
        endcase
        emit(t[7:0]);
        emit(t[15:8]);
      end
    end
    boot(3);
    for (int i = 0; i < n; i++) step("random");
    chk_images("random");
  endtask

  initial begin
    int c;
    // reset vector and first fetch
    clear(16'hF000);
    emit(8'hA9); emit(8'h01);
    boot(5);
    chk("vector pc literal", dut.pc_q, 16'hF000);
    @(negedge ph1);
    chk("pc after first fetch", dut.pc_q, 16'hF001);
    @(negedge ph1);
    chk("first lda a", dut.a_q, 8'h01);
    // load/store chain ending in a JMP loop
    clear(16'hF000);
    foreach (m_r[i]) m_r[i] = 8'h00;
    begin
      logic [7:0] prog [17] = '{8'hA9, 8'h55, 8'h8D, 8'h2A, 8'h02, 8'hA2, 8'h33, 8'h86, 8'h10,
                                8'hA4, 8'h10, 8'h8C, 8'h00, 8'h01, 8'h4C, 8'h0C, 8'hF0};
      foreach (prog[i]) emit(prog[i]);
    end
    boot(2);
    for (int i = 0; i < 16; i++) step("chain");
    chk("chain within 170 cycles", int'(cyc_total <= 170), 1);
    chk("chain ram 554", dut.mem.RAM[554], 8'h55);
    chk("chain ram 0x10", dut.mem.RAM[16'h10], 8'h33);
    chk("chain ram 0x100", dut.mem.RAM[16'h100], 8'h33);
    chk("chain y", dut.y_q, 8'h33);
    chk_images("chain");
    // flags
    clear(16'hF000);
    emit(8'hA9); emit(8'h00); emit(8'hA2); emit(8'h80); emit(8'h8A);
    emit(8'h4C); emit(8'h05); emit(8'hF0);
    boot(2);
    step("lda #0");
    chk("model z after lda #0", m_z, 1);
    chk("lda #0 z", dut.z_q, 1);
    chk("lda #0 n", dut.n_q, 0);
    step("ldx #80");
    chk("ldx #80 z", dut.z_q, 0);
    chk("ldx #80 n", dut.n_q, 1);
    step("txa");
    chk("txa a", dut.a_q, 8'h80);
    chk("txa n", dut.n_q, 1);
    step("jmp self");
    // cycle counts: LDA abs then NOP, STA zp
    clear(16'hF000);
    emit(8'hAD); emit(8'h34); emit(8'h12); emit(8'hEA);
    emit(8'hA9); emit(8'h77); emit(8'h85); emit(8'h40); emit(8'hEA);
    boot(2);
    m_step(c);
    chk("model lda abs cycles", c, 4);
    repeat (3) @(negedge ph1);
    chk("lda abs exec addr", dut.bus_addr, 16'h1234);
    @(negedge ph1);
    check_state("lda abs");
    chk("nop fetch addr", dut.bus_addr, 16'hF003);
    step("nop");
    step("lda #77");
    m_step(c);
    chk("model sta zp cycles", c, 3);
    repeat (2) @(negedge ph1);
    chk("sta zp before 3rd edge", dut.mem.RAM[16'h40], 8'h00);
    @(negedge ph1);
    chk("sta zp on 3rd edge", dut.mem.RAM[16'h40], 8'h77);
    check_state("sta zp");
    // reset during a store: OP2 then EXEC
    clear(16'hF000);
    emit(8'hA9); emit(8'h77); emit(8'h8D); emit(8'h00); emit(8'h02); emit(8'hEA);
    m_ram[16'h200] = 8'hA5;
    boot(2);
    step("pre-store lda");
    repeat (2) @(negedge ph1);
    do_reset(3);
    chk("reset in op2 ram", dut.mem.RAM[16'h200], 8'hA5);
    chk("reset in op2 a", dut.a_q, 8'h00);
    step("pre-store lda 2");
    repeat (3) @(negedge ph1);
    do_reset(2);
    chk("reset in exec ram", dut.mem.RAM[16'h200], 8'hA5);
    step("lda after reset");
    step("sta after reset");
    chk("sta completes", dut.mem.RAM[16'h200], 8'h77);
    // map edges
    clear(16'hF000);
    emit(8'hA9); emit(8'h5A); emit(8'h8D); emit(8'h00); emit(8'h08);
    emit(8'h8D); emit(8'h00); emit(8'hF1); emit(8'hAD); emit(8'h00); emit(8'h08);
    boot(2);
    for (int i = 0; i < 4; i++) step("map");
    chk("lda 0x0800 a", dut.a_q, 8'h00);
    chk("lda 0x0800 z", dut.z_q, 1);
    chk("rom 0xF100 kept", dut.mem.ROM[12'h100], 8'hEA);
    chk_images("map");
    // PC wrap from 0xFFFF into RAM
    clear(16'hFFFE);
    m_ram[0] = 8'hA9;
    m_ram[1] = 8'h42;
    boot(2);
    for (int i = 0; i < 3; i++) step("wrap");
    chk("wrap a", dut.a_q, 8'h42);
    chk("wrap pc", dut.pc_q, 16'h0002);
    // randomized programs
    for (int s = 0; s < 3; s++) gen_random(200);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
